fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'd0, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction-buffer entries and maximum in-flight plus buffered fetches.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_gnt  input  1  request accepted this cycle.
REQ-008 imem_rvalid  input  1  fetch data valid; in order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  fetched instruction.
REQ-010 redirect  input  1  control transfer taken; flush the stream.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 id_valid  output  1  buffer head is presented to IF/ID.
REQ-013 id_ready  input  1  IF/ID consumes the head this cycle.
REQ-014 id_instr  output  32  head instruction.
REQ-015 id_pc  output  32  head instruction address.
REQ-016 id_npc  output  32  id_pc+4; matches the {npc,instr} IF/ID packing.

Function
REQ-017 Sole FSM states: IDLE, RUN, FLUSH; encoded 2 bits.
REQ-018 IDLE lasts exactly one cycle after reset and then goes to RUN; no request is issued in IDLE.
REQ-019 In RUN, imem_req=1 iff inflight+occupancy<DEPTH; imem_addr=fetch_pc.
REQ-020 On imem_req&&imem_gnt: fetch_pc += 4 (mod 2^32, wraps silently); inflight += 1.
REQ-021 imem_req and imem_addr hold stable while imem_req=1 and imem_gnt=0.
REQ-022 In RUN, imem_rvalid pushes {pc_of_response, imem_rdata} into the FIFO and decrements inflight; the response PC comes from a DEPTH-entry address tag queue.
REQ-023 id_valid = FIFO non-empty; id_instr/id_pc/id_npc come from the head register, with no combinational path from imem_rdata.
REQ-024 id_valid&&id_ready pops the head; push and pop in the same cycle are legal at any occupancy.
REQ-025 The credit rule guarantees a push never occurs when full; overflow is an assertion failure.
REQ-026 redirect (any state): the FIFO empties next cycle, fetch_pc=redirect_pc, and discard=inflight minus any response arriving in that same cycle, which is dropped.
REQ-027 After redirect: state=FLUSH if discard>0, else RUN; imem_req=0 in FLUSH.
REQ-028 In FLUSH, each imem_rvalid decrements discard and inflight with no push; discard reaching 0 returns to RUN next cycle.
REQ-029 redirect during FLUSH replaces fetch_pc and recomputes discard from the current inflight.
REQ-030 redirect takes priority over pop, push, and grant in the same cycle; a grant coinciding with redirect still counts as in-flight and is discarded.
REQ-031 id_valid=0 in the cycle after redirect.
REQ-032 Misaligned redirect_pc has bits[1:0] forced to 0.

Reset
REQ-033 On reset: fetch_pc=RESET_PC, state=IDLE, inflight=0, discard=0, FIFO empty, imem_req=0, id_valid=0, and id_instr/id_pc/id_npc=0.
REQ-034 Reset mid-operation abandons in-flight fetches; responses arriving while reset=1 or in IDLE are ignored.

Structure
REQ-035 Shared package fetch_pkg holds the FSM state encodings, the default RESET_PC, and the FIFO entry width (64).
REQ-036 The FIFO and tag queue live in a single sub-module, fetch_fifo (parameterised width/depth, valid/ready, full/empty flags).

Verification
REQ-037 Reset, then imem_gnt=1 and 1-cycle rvalid, with id_ready=1 -> id_pc sequence 0,4,8,12, id_npc=id_pc+4, first id_valid by cycle 3.
REQ-038 id_ready=0 for 6 cycles -> exactly 2 requests granted, then imem_req=0; no data lost; release delivers 0,4 in order.
REQ-039 redirect to 0x100 with 2 fetches in flight -> FLUSH, 2 responses dropped, next id_pc=0x100.
REQ-040 redirect coinciding with rvalid and pop -> the coinciding response is dropped, the FIFO is empty, and fetch resumes at redirect_pc.
REQ-041 imem_gnt=0 for 4 cycles -> imem_addr stable at 8 throughout.
REQ-042 RESET_PC=0xFFFFFFFC -> second fetch address is 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encodings and sizing constants for the fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  // Buffer entry packs {pc, instr}; next-pc is rebuilt from pc at the head.
  localparam int ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular FIFO with count and flags; holds the instruction buffer and the address tag queue
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign pop_valid_o  = !empty_o;
  // A pop frees the slot in the same cycle, so push+pop is accepted even when full.
  assign push_ready_o = !full_o || pop_ready_i;
  assign pop          = pop_valid_o && pop_ready_i;
  assign push         = push_valid_i && push_ready_o;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset || clear_i)
    push_valid_i |-> push_ready_o);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with in-order response buffer and redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0]      occupancy;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        tag_pc;
  logic               grant;
  logic               rsp;
  logic               buf_push;
  logic               buf_pop;
  logic               tag_push;

  logic               buf_push_ready_unused, buf_full_unused, buf_empty_unused;
  logic               tag_push_ready_unused, tag_pop_valid_unused;
  logic               tag_full_unused, tag_empty_unused;
  logic [CW-1:0]      tag_count_unused;

  // Credits cover both outstanding fetches and buffered entries, so a response always has a slot.
  assign imem_req  = (state_q == ST_RUN) &&
                     (({1'b0, inflight_q} + {1'b0, occupancy}) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign grant    = imem_req && imem_gnt;
  assign rsp      = imem_rvalid && (state_q != ST_IDLE) && (inflight_q != '0);
  assign buf_push = rsp && (state_q == ST_RUN) && !redirect;
  assign buf_pop  = id_ready && !redirect;
  assign tag_push = grant && !redirect;

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (redirect),
    .push_valid_i (buf_push),
    .push_ready_o (buf_push_ready_unused),
    .push_data_i  ({tag_pc, imem_rdata}),
    .pop_valid_o  (id_valid),
    .pop_ready_i  (buf_pop),
    .pop_data_o   (head),
    .full_o       (buf_full_unused),
    .empty_o      (buf_empty_unused),
    .count_o      (occupancy)
  );

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (redirect),
    .push_valid_i (tag_push),
    .push_ready_o (tag_push_ready_unused),
    .push_data_i  (fetch_pc_q),
    .pop_valid_o  (tag_pop_valid_unused),
    .pop_ready_i  (buf_push),
    .pop_data_o   (tag_pc),
    .full_o       (tag_full_unused),
    .empty_o      (tag_empty_unused),
    .count_o      (tag_count_unused)
  );

  assign id_instr = id_valid ? head[31:0]          : 32'd0;
  assign id_pc    = id_valid ? head[63:32]         : 32'd0;
  assign id_npc   = id_valid ? head[63:32] + 32'd4 : 32'd0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(grant) - CW'(rsp);
    discard_d  = discard_q;
    if (redirect) begin
      // Everything still outstanding, including a same-cycle grant, belongs to the old stream.
      fetch_pc_d = redirect_pc & ~32'd3;
      discard_d  = inflight_d;
      state_d    = (inflight_d != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        end
        ST_FLUSH: begin
          if (rsp) discard_d = discard_q - CW'(1);
          if (discard_d == '0) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table and sequence checks for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc, id_npc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_npc;

  int checks = 0;
  int errors = 0;
  int grants = 0;
  bit rsp_en = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] newg[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'd0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_npc(id_npc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(w_valid), .id_ready(id_ready),
    .id_instr(w_instr), .id_pc(w_pc), .id_npc(w_npc)
  );

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[29];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory answers the oldest grant from an earlier cycle when enabled.
  task automatic tick();
    imem_rvalid = rsp_en && (pend.size() > 0);
    imem_rdata  = imem_rvalid ? instr_of(pend[0]) : 32'd0;
    #1;
    if (imem_req && imem_gnt) begin
      newg.push_back(imem_addr);
      grants++;
    end
    if (imem_rvalid) void'(pend.pop_front());
    @(posedge clk);
    #1;
    while (newg.size() > 0) pend.push_back(newg.pop_front());
    imem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_gnt = 1'b0; id_ready = 1'b0; redirect = 1'b0;
    imem_rvalid = 1'b0; rsp_en = 1'b1;
    pend.delete(); newg.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_npc", id_npc, 32'd0);
    reset = 1'b0;
    grants = 0;
  endtask

  task automatic set_in(input bit g, input bit r, input bit e);
    imem_gnt = g; id_ready = r; rsp_en = e; redirect = 1'b0;
  endtask

  task automatic wait_head(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (!id_valid && n < 12) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, {31'd0, id_valid}, 32'd1);
    chk({name, "_pc"}, id_pc, exp_pc);
    chk({name, "_instr"}, id_instr, instr_of(exp_pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // streaming with 1-cycle grant/response
    tbl[0]  = '{1, 1, 1, 0, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 1, 1, 1, 32'h0,  0, 32'h0};
    tbl[2]  = '{0, 1, 1, 1, 32'h4,  0, 32'h0};
    tbl[3]  = '{0, 1, 1, 0, 32'h0,  1, 32'h0};
    tbl[4]  = '{0, 1, 1, 1, 32'h8,  1, 32'h4};
    tbl[5]  = '{0, 1, 1, 1, 32'hC,  0, 32'h0};
    tbl[6]  = '{0, 1, 1, 0, 32'h0,  1, 32'h8};
    tbl[7]  = '{0, 1, 1, 1, 32'h10, 1, 32'hC};
    // consumer stall: two grants fill the credits, then release
    tbl[8]  = '{1, 1, 0, 0, 32'h0,  0, 32'h0};
    tbl[9]  = '{0, 1, 0, 1, 32'h0,  0, 32'h0};
    tbl[10] = '{0, 1, 0, 1, 32'h4,  0, 32'h0};
    tbl[11] = '{0, 1, 0, 0, 32'h0,  1, 32'h0};
    tbl[12] = '{0, 1, 0, 0, 32'h0,  1, 32'h0};
    tbl[13] = '{0, 1, 0, 0, 32'h0,  1, 32'h0};
    tbl[14] = '{0, 1, 0, 0, 32'h0,  1, 32'h0};
    tbl[15] = '{0, 1, 1, 0, 32'h0,  1, 32'h0};
    tbl[16] = '{0, 1, 1, 1, 32'h8,  1, 32'h4};
    tbl[17] = '{0, 1, 1, 1, 32'hC,  0, 32'h0};
    // grant withheld for four cycles while requesting address 8
    tbl[18] = '{1, 1, 1, 0, 32'h0,  0, 32'h0};
    tbl[19] = '{0, 1, 1, 1, 32'h0,  0, 32'h0};
    tbl[20] = '{0, 1, 1, 1, 32'h4,  0, 32'h0};
    tbl[21] = '{0, 1, 1, 0, 32'h0,  1, 32'h0};
    tbl[22] = '{0, 0, 1, 1, 32'h8,  1, 32'h4};
    tbl[23] = '{0, 0, 1, 1, 32'h8,  0, 32'h0};
    tbl[24] = '{0, 0, 1, 1, 32'h8,  0, 32'h0};
    tbl[25] = '{0, 0, 1, 1, 32'h8,  0, 32'h0};
    tbl[26] = '{0, 1, 1, 1, 32'h8,  0, 32'h0};
    tbl[27] = '{0, 1, 1, 1, 32'hC,  0, 32'h0};
    tbl[28] = '{0, 1, 1, 0, 32'h0,  1, 32'h8};

    for (int i = 0; i < 29; i++) begin
      if (tbl[i].rst) do_reset();
      set_in(tbl[i].gnt, tbl[i].rdy, 1'b1);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_val});
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_pc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_npc", i), id_npc, tbl[i].e_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), id_instr, instr_of(tbl[i].e_pc));
      end
      if (i == 1) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_addr1", w_addr, 32'h0000_0000);
      if (i == 14) chk("stall_grants", grants, 2);
      tick();
    end

    // redirect with two fetches outstanding
    do_reset();
    set_in(1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("r1_credit_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    set_in(1'b1, 1'b1, 1'b1);
    chk("r1_flush_req", {31'd0, imem_req}, 32'd0);
    chk("r1_flush_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("r1_flush_req2", {31'd0, imem_req}, 32'd0);
    tick();
    chk("r1_resume_req", {31'd0, imem_req}, 32'd1);
    chk("r1_resume_addr", imem_addr, 32'h100);
    wait_head("r1_head", 32'h100);

    // redirect (misaligned) coinciding with a response and a pop
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    chk("r2_empty", {31'd0, id_valid}, 32'd0);
    chk("r2_req", {31'd0, imem_req}, 32'd1);
    chk("r2_addr", imem_addr, 32'h200);
    wait_head("r2_head", 32'h200);

    // redirect coinciding with a grant: that fetch is still discarded
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    chk("r3_flush_req", {31'd0, imem_req}, 32'd0);
    chk("r3_flush_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("r3_resume_req", {31'd0, imem_req}, 32'd1);
    chk("r3_resume_addr", imem_addr, 32'h300);
    wait_head("r3_head", 32'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
